// File: rtl/register_file_2r1w_if.sv
// Bus bundle for register_file_2r1w: two read ports, one write port and the
// reservation/scoreboard signals. The master drives requests, the slave is the register file.
interface register_file_2r1w_if #(
    parameter int WIDTH  = 16,
    parameter int DEPTH  = 8,
    parameter int ADDR_W = $clog2(DEPTH)
);
    logic              rd_en_a;
    logic [ADDR_W-1:0] rd_addr_a;
    logic [WIDTH-1:0]  rd_data_a;
    logic              rd_valid_a;
    logic              rd_busy_a;

    logic              rd_en_b;
    logic [ADDR_W-1:0] rd_addr_b;
    logic [WIDTH-1:0]  rd_data_b;
    logic              rd_valid_b;
    logic              rd_busy_b;

    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [WIDTH-1:0]  wr_data;

    logic              rsv_en;
    logic [ADDR_W-1:0] rsv_addr;
    logic [DEPTH-1:0]  pending;

    modport master (
        output rd_en_a, rd_addr_a, rd_en_b, rd_addr_b,
        output wr_en, wr_addr, wr_data, rsv_en, rsv_addr,
        input  rd_data_a, rd_valid_a, rd_busy_a,
        input  rd_data_b, rd_valid_b, rd_busy_b, pending
    );

    modport slave (
        input  rd_en_a, rd_addr_a, rd_en_b, rd_addr_b,
        input  wr_en, wr_addr, wr_data, rsv_en, rsv_addr,
        output rd_data_a, rd_valid_a, rd_busy_a,
        output rd_data_b, rd_valid_b, rd_busy_b, pending
    );
endinterface

// File: rtl/register_file_2r1w.sv
// Two-read, one-write register file with registered reads, optional write
// forwarding, optional hard-wired zero register and a pending-write scoreboard.
module register_file_2r1w #(
    parameter int WIDTH    = 16,
    parameter int DEPTH    = 8,
    parameter int ADDR_W   = $clog2(DEPTH),
    parameter int BYPASS   = 1,
    parameter int ZERO_REG = 0
) (
    input logic                clk,
    input logic                rst,
    register_file_2r1w_if.slave bus
);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [DEPTH-1:0] pend;
    logic [DEPTH-1:0] pend_nxt;
    logic             wr_ok;
    logic             rsv_ok;
    logic [WIDTH-1:0] data_a_nxt, data_b_nxt;
    logic             busy_a_nxt, busy_b_nxt;

    // Address refers to a real, writable register.
    function automatic logic addr_ok(input logic [ADDR_W-1:0] a);
        return (int'(a) < DEPTH) && !((ZERO_REG != 0) && (a == '0));
    endfunction

    assign wr_ok       = bus.wr_en  && addr_ok(bus.wr_addr);
    assign rsv_ok      = bus.rsv_en && addr_ok(bus.rsv_addr);
    assign bus.pending = pend;

    // Reserve is applied after the write clear so a same-cycle reserve wins.
    always_comb begin
        pend_nxt = pend;
        if (wr_ok)
            pend_nxt[bus.wr_addr] = 1'b0;
        if (rsv_ok)
            pend_nxt[bus.rsv_addr] = 1'b1;
    end

    always_comb begin
        data_a_nxt = '0;
        busy_a_nxt = 1'b0;
        if (addr_ok(bus.rd_addr_a)) begin
            if ((BYPASS != 0) && wr_ok && (bus.wr_addr == bus.rd_addr_a)) begin
                data_a_nxt = bus.wr_data;
            end else begin
                data_a_nxt = mem[bus.rd_addr_a];
                busy_a_nxt = pend[bus.rd_addr_a];
            end
        end
    end

    always_comb begin
        data_b_nxt = '0;
        busy_b_nxt = 1'b0;
        if (addr_ok(bus.rd_addr_b)) begin
            if ((BYPASS != 0) && wr_ok && (bus.wr_addr == bus.rd_addr_b)) begin
                data_b_nxt = bus.wr_data;
            end else begin
                data_b_nxt = mem[bus.rd_addr_b];
                busy_b_nxt = pend[bus.rd_addr_b];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < DEPTH; i++)
                mem[i] <= '0;
            pend           <= '0;
            bus.rd_data_a  <= '0;
            bus.rd_valid_a <= 1'b0;
            bus.rd_busy_a  <= 1'b0;
            bus.rd_data_b  <= '0;
            bus.rd_valid_b <= 1'b0;
            bus.rd_busy_b  <= 1'b0;
        end else begin
            if (wr_ok)
                mem[bus.wr_addr] <= bus.wr_data;
            pend           <= pend_nxt;
            bus.rd_valid_a <= bus.rd_en_a;
            bus.rd_valid_b <= bus.rd_en_b;
            if (bus.rd_en_a) begin
                bus.rd_data_a <= data_a_nxt;
                bus.rd_busy_a <= busy_a_nxt;
            end
            if (bus.rd_en_b) begin
                bus.rd_data_b <= data_b_nxt;
                bus.rd_busy_b <= busy_b_nxt;
            end
        end
    end
endmodule

// File: tb/tb_register_file_2r1w.sv
// Directed bench for register_file_2r1w: four instances cover the default
// configuration, BYPASS=0, ZERO_REG=1 and a non-power-of-two depth.
module tb_register_file_2r1w;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    register_file_2r1w_if #(.WIDTH(16), .DEPTH(8)) b0 ();
    register_file_2r1w_if #(.WIDTH(16), .DEPTH(8)) b1 ();
    register_file_2r1w_if #(.WIDTH(16), .DEPTH(8)) b2 ();
    register_file_2r1w_if #(.WIDTH(16), .DEPTH(6)) b3 ();

    register_file_2r1w #(.WIDTH(16), .DEPTH(8), .BYPASS(1), .ZERO_REG(0))
        u0 (.clk(clk), .rst(rst), .bus(b0.slave));
    register_file_2r1w #(.WIDTH(16), .DEPTH(8), .BYPASS(0), .ZERO_REG(0))
        u1 (.clk(clk), .rst(rst), .bus(b1.slave));
    register_file_2r1w #(.WIDTH(16), .DEPTH(8), .BYPASS(1), .ZERO_REG(1))
        u2 (.clk(clk), .rst(rst), .bus(b2.slave));
    register_file_2r1w #(.WIDTH(16), .DEPTH(6), .BYPASS(1), .ZERO_REG(0))
        u3 (.clk(clk), .rst(rst), .bus(b3.slave));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        {b0.rd_en_a, b0.rd_en_b, b0.wr_en, b0.rsv_en} = '0;
        {b1.rd_en_a, b1.rd_en_b, b1.wr_en, b1.rsv_en} = '0;
        {b2.rd_en_a, b2.rd_en_b, b2.wr_en, b2.rsv_en} = '0;
        {b3.rd_en_a, b3.rd_en_b, b3.wr_en, b3.rsv_en} = '0;
        {b0.rd_addr_a, b0.rd_addr_b, b0.wr_addr, b0.rsv_addr, b0.wr_data} = '0;
        {b1.rd_addr_a, b1.rd_addr_b, b1.wr_addr, b1.rsv_addr, b1.wr_data} = '0;
        {b2.rd_addr_a, b2.rd_addr_b, b2.wr_addr, b2.rsv_addr, b2.wr_data} = '0;
        {b3.rd_addr_a, b3.rd_addr_b, b3.wr_addr, b3.rsv_addr, b3.wr_data} = '0;

        // reset state
        tick();
        tick();
        check("rst_data_a", b0.rd_data_a, 0);
        check("rst_valid_a", b0.rd_valid_a, 0);
        check("rst_pending", b0.pending, 0);
        #2 rst = 1'b0;

        // basic readback
        b0.wr_en = 1; b0.wr_addr = 3; b0.wr_data = 16'h1234; tick();
        b0.wr_addr = 5; b0.wr_data = 16'hBEEF; tick();
        b0.wr_en = 0;
        b0.rd_en_a = 1; b0.rd_addr_a = 3; b0.rd_en_b = 1; b0.rd_addr_b = 5; tick();
        check("rb_data_a", b0.rd_data_a, 32'h1234);
        check("rb_data_b", b0.rd_data_b, 32'hBEEF);
        check("rb_valid_a", b0.rd_valid_a, 1);
        check("rb_valid_b", b0.rd_valid_b, 1);
        check("rb_busy_a", b0.rd_busy_a, 0);
        check("rb_busy_b", b0.rd_busy_b, 0);
        b0.rd_en_a = 0; b0.rd_en_b = 0; tick();
        check("idle_valid_a", b0.rd_valid_a, 0);
        check("idle_valid_b", b0.rd_valid_b, 0);
        check("idle_hold_a", b0.rd_data_a, 32'h1234);
        check("idle_hold_b", b0.rd_data_b, 32'hBEEF);

        // both ports on the same register
        b0.rd_en_a = 1; b0.rd_addr_a = 5; b0.rd_en_b = 1; b0.rd_addr_b = 5; tick();
        check("same_a", b0.rd_data_a, 32'hBEEF);
        check("same_b", b0.rd_data_b, 32'hBEEF);
        b0.rd_en_b = 0;

        // bypass with BYPASS=1
        b0.wr_en = 1; b0.wr_addr = 2; b0.wr_data = 16'h00AA; b0.rd_addr_a = 2; tick();
        check("byp_data_a", b0.rd_data_a, 32'h00AA);
        check("byp_busy_a", b0.rd_busy_a, 0);
        b0.wr_en = 0; b0.rd_en_a = 0;

        // scoreboard
        b0.rsv_en = 1; b0.rsv_addr = 4; tick();
        check("sb_rsv4", b0.pending, 32'h10);
        b0.rsv_en = 0; b0.rd_en_a = 1; b0.rd_addr_a = 4; tick();
        check("sb_busy4", b0.rd_busy_a, 1);
        b0.rd_en_a = 0; b0.wr_en = 1; b0.wr_addr = 4; b0.wr_data = 16'h0777; tick();
        check("sb_clr4", b0.pending, 0);
        b0.rsv_en = 1; b0.rsv_addr = 6; b0.wr_addr = 6; tick();
        check("sb_rsvwr6", b0.pending, 32'h40);
        b0.rsv_en = 0; b0.wr_en = 0; b0.rd_en_a = 1; b0.rd_addr_a = 6; tick();
        check("sb_data6", b0.rd_data_a, 32'h0777);
        check("sb_busy6", b0.rd_busy_a, 1);
        // reserve + write + bypassed read of r1 in one cycle
        b0.rsv_en = 1; b0.rsv_addr = 1; b0.wr_en = 1; b0.wr_addr = 1; b0.wr_data = 16'h0055;
        b0.rd_addr_a = 1; tick();
        check("sb_byp_data1", b0.rd_data_a, 32'h0055);
        check("sb_byp_busy1", b0.rd_busy_a, 0);
        check("sb_pend_42", b0.pending, 32'h42);
        b0.rsv_en = 0; b0.wr_en = 0; b0.rd_en_a = 0;

        // ZERO_REG=0: r0 is an ordinary register
        b0.wr_en = 1; b0.wr_addr = 0; b0.wr_data = 16'hFFFF; tick();
        b0.wr_en = 0; b0.rd_en_a = 1; b0.rd_addr_a = 0; tick();
        check("nz_r0", b0.rd_data_a, 32'hFFFF);
        b0.rd_en_a = 0;

        // BYPASS=0: read sees pre-write contents and pending bit
        b1.wr_en = 1; b1.wr_addr = 2; b1.wr_data = 16'h0011; tick();
        b1.wr_data = 16'h00AA; b1.rd_en_a = 1; b1.rd_addr_a = 2; tick();
        check("nb_old", b1.rd_data_a, 32'h0011);
        b1.wr_en = 0; tick();
        check("nb_new", b1.rd_data_a, 32'h00AA);
        b1.rd_en_a = 0; b1.rsv_en = 1; b1.rsv_addr = 3; tick();
        b1.rsv_en = 0; b1.wr_en = 1; b1.wr_addr = 3; b1.wr_data = 16'h3333;
        b1.rd_en_a = 1; b1.rd_addr_a = 3; tick();
        check("nb_busy_old", b1.rd_busy_a, 1);
        check("nb_data_old", b1.rd_data_a, 0);
        check("nb_pend_clr", b1.pending, 0);
        b1.wr_en = 0; b1.rd_en_a = 0;

        // ZERO_REG=1
        b2.wr_en = 1; b2.wr_addr = 0; b2.wr_data = 16'hFFFF; b2.rsv_en = 1; b2.rsv_addr = 0; tick();
        b2.wr_en = 0; b2.rsv_en = 0;
        b2.rd_en_a = 1; b2.rd_addr_a = 0; b2.rd_en_b = 1; b2.rd_addr_b = 0; tick();
        check("z_data_a", b2.rd_data_a, 0);
        check("z_data_b", b2.rd_data_b, 0);
        check("z_busy_a", b2.rd_busy_a, 0);
        check("z_busy_b", b2.rd_busy_b, 0);
        check("z_pending", b2.pending, 0);
        b2.rd_en_a = 0; b2.rd_en_b = 0;

        // DEPTH=6: addresses 6 and 7 are out of range
        b3.wr_en = 1; b3.wr_addr = 5; b3.wr_data = 16'h1111; tick();
        b3.wr_addr = 7; b3.wr_data = 16'hDEAD; b3.rsv_en = 1; b3.rsv_addr = 7; tick();
        b3.wr_addr = 6; b3.wr_data = 16'hBEEF; b3.rsv_addr = 6; tick();
        b3.wr_en = 0; b3.rsv_en = 0;
        check("d6_pending", b3.pending, 0);
        b3.rd_en_a = 1; b3.rd_addr_a = 7; b3.rd_en_b = 1; b3.rd_addr_b = 5; tick();
        check("d6_oor_data", b3.rd_data_a, 0);
        check("d6_oor_busy", b3.rd_busy_a, 0);
        check("d6_r5", b3.rd_data_b, 32'h1111);
        b3.rd_addr_a = 0; b3.rd_addr_b = 1; tick();
        check("d6_r0", b3.rd_data_a, 0);
        check("d6_r1", b3.rd_data_b, 0);
        b3.rd_en_a = 0; b3.rd_en_b = 0;

        // asynchronous reset mid-stream
        b0.rsv_en = 1; b0.rsv_addr = 2; tick();
        b0.rsv_addr = 3; b0.rd_en_a = 1; b0.rd_addr_a = 5; tick();
        b0.rsv_en = 0; b0.rd_en_a = 0;
        check("ar_pre_pending", b0.pending, 32'h4E);
        check("ar_pre_valid", b0.rd_valid_a, 1);
        #2 rst = 1'b1;
        #1;
        check("ar_pending", b0.pending, 0);
        check("ar_valid_a", b0.rd_valid_a, 0);
        check("ar_data_a", b0.rd_data_a, 0);
        check("ar_data_b", b0.rd_data_b, 0);
        #1 rst = 1'b0;
        b0.rd_en_a = 1; b0.rd_addr_a = 3; b0.rd_en_b = 1; b0.rd_addr_b = 0; tick();
        check("ar_r3", b0.rd_data_a, 0);
        check("ar_r0", b0.rd_data_b, 0);
        check("ar_valid_after", b0.rd_valid_a, 1);
        b0.rd_addr_a = 5; b0.rd_addr_b = 1; tick();
        check("ar_r5", b0.rd_data_a, 0);
        check("ar_r1", b0.rd_data_b, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
